// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the architectural PC, fetches one instruction at a time
// over a req/gnt/rvalid memory handshake, hands it to decode over valid/ready,
// and redirects on flush while discarding any response still in flight.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | request asserted at pc, waiting for imem_gnt
// WAIT  | request granted, waiting for imem_rvalid (unbounded latency)
// HOLD  | instruction presented to decode, waiting for inst_ready
// DRAIN | stale request outstanding after a flush, discard its response
module pc_fetch_unit #(
    parameter logic [29:0] RESET_PC = 30'h00000C00,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [29:0]      pc,
    input  logic [29:0]      npc,
    output logic             imem_req,
    output logic [29:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [29:0]      inst_pc,
    input  logic             inst_ready,
    input  logic             flush,
    input  logic [29:0]      flush_pc,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Output decode from state; the request is masked while reset is held
    // because the reset state is FETCH.
    assign imem_req   = rst_n && (state == FETCH);
    assign imem_addr  = pc;
    assign inst_valid = (state == HOLD);

    // Fetch sequencer: flush has priority over every other event in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            inst      <= 32'h0;
            inst_pc   <= 30'h0;
            fetch_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (flush) begin
                        pc <= flush_pc;
                        // A grant in the flush cycle already launched the old
                        // pc, so its response still has to be swallowed.
                        state <= imem_gnt ? DRAIN : FETCH;
                    end else if (imem_gnt) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        pc    <= flush_pc;
                        state <= imem_rvalid ? FETCH : DRAIN;
                    end else if (imem_rvalid) begin
                        inst    <= imem_rdata;
                        inst_pc <= pc;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        pc    <= flush_pc;
                        state <= FETCH;
                    end else if (inst_ready) begin
                        pc        <= npc;
                        fetch_cnt <= fetch_cnt + CNT_ONE;
                        state     <= FETCH;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        pc <= flush_pc;
                    end
                    // The stale response ends the drain even if a flush lands
                    // in the same cycle; waiting for a second response would
                    // hang because only one request was ever outstanding.
                    if (imem_rvalid) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed, table-driven bench for pc_fetch_unit.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [29:0] pc;
    logic [29:0] npc;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic        inst_ready;
    logic        flush;
    logic [29:0] flush_pc;
    logic [31:0] fetch_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pc_fetch_unit #(.RESET_PC(30'h00000C00), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .npc         (npc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_cnt   (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic [29:0] npc;
        logic        fl;
        logic [29:0] flpc;
        logic        req;
        logic [29:0] addr;
        logic        iv;
        logic [31:0] inst;
        logic [29:0] ipc;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic gnt, logic rv, logic [31:0] rdata, logic rdy,
                                logic [29:0] n, logic fl, logic [29:0] flpc,
                                logic req, logic [29:0] addr, logic iv,
                                logic [31:0] ins, logic [29:0] ipc, logic [31:0] cnt);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.npc = n;
        v.fl = fl; v.flpc = flpc; v.req = req; v.addr = addr; v.iv = iv;
        v.inst = ins; v.ipc = ipc; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic req, input logic [29:0] addr,
                            input logic iv, input logic [31:0] ins,
                            input logic [29:0] ipc, input logic [31:0] cnt);
        chk({tag, ".imem_req"},   64'(imem_req),   64'(req));
        chk({tag, ".imem_addr"},  64'(imem_addr),  64'(addr));
        chk({tag, ".inst_valid"}, 64'(inst_valid), 64'(iv));
        chk({tag, ".inst"},       64'(inst),       64'(ins));
        chk({tag, ".inst_pc"},    64'(inst_pc),    64'(ipc));
        chk({tag, ".fetch_cnt"},  64'(fetch_cnt),  64'(cnt));
    endtask

    task automatic idle_inputs();
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0;
        inst_ready = 0; npc = 30'h0; flush = 0; flush_pc = 30'h0;
    endtask

    localparam logic [31:0] D  = 32'h24080001;
    localparam logic [31:0] I2 = 32'h8C220004;
    localparam logic [31:0] I3 = 32'h3C011234;
    localparam logic [31:0] I4 = 32'h00A00020;
    localparam logic [31:0] I5 = 32'h12345678;

    initial begin
        //            gnt rv rdata         rdy npc           fl flpc        req addr          iv inst ipc       cnt
        // sequential stream, zero-wait memory
        vecs.push_back(mk(1, 0, 32'h0,        0, 30'h0,       0, 30'h0,     0, 30'hC00,     0, 32'h0, 30'h0,   0));
        vecs.push_back(mk(0, 1, D,            0, 30'h0,       0, 30'h0,     0, 30'hC00,     1, D,  30'hC00,    0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 30'hC01,     0, 30'h0,     1, 30'hC01,     0, D,  30'hC00,    1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 30'h0,       0, 30'h0,     0, 30'hC01,     0, D,  30'hC00,    1));
        vecs.push_back(mk(0, 1, D,            0, 30'h0,       0, 30'h0,     0, 30'hC01,     1, D,  30'hC01,    1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 30'hC02,     0, 30'h0,     1, 30'hC02,     0, D,  30'hC01,    2));
        vecs.push_back(mk(1, 0, 32'h0,        0, 30'h0,       0, 30'h0,     0, 30'hC02,     0, D,  30'hC01,    2));
        vecs.push_back(mk(0, 1, D,            0, 30'h0,       0, 30'h0,     0, 30'hC02,     1, D,  30'hC02,    2));
        vecs.push_back(mk(0, 0, 32'h0,        1, 30'hC03,     0, 30'h0,     1, 30'hC03,     0, D,  30'hC02,    3));
        // rvalid in the grant cycle is ignored; one extra cycle of latency
        vecs.push_back(mk(1, 1, 32'h11111111, 0, 30'h0,       0, 30'h0,     0, 30'hC03,     0, D,  30'hC02,    3));
        vecs.push_back(mk(0, 0, 32'h0,        0, 30'h0,       0, 30'h0,     0, 30'hC03,     0, D,  30'hC02,    3));
        vecs.push_back(mk(0, 1, I2,           0, 30'h0,       0, 30'h0,     0, 30'hC03,     1, I2, 30'hC03,    3));
        // back-pressure for 5 cycles, stray rdata must not disturb the held inst
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 30'hC40, 0, 30'h0,   0, 30'hC03,     1, I2, 30'hC03,    3));
        vecs.push_back(mk(0, 0, 32'h0,        1, 30'hC40,     0, 30'h0,     1, 30'hC40,     0, I2, 30'hC03,    4));
        // flush in FETCH without grant
        vecs.push_back(mk(0, 0, 32'h0,        0, 30'h0,       1, 30'h2000,  1, 30'h2000,    0, I2, 30'hC03,    4));
        // flush in WAIT before rvalid -> DRAIN, late data discarded
        vecs.push_back(mk(1, 0, 32'h0,        0, 30'h0,       0, 30'h0,     0, 30'h2000,    0, I2, 30'hC03,    4));
        vecs.push_back(mk(0, 0, 32'h0,        0, 30'h0,       1, 30'h1060,  0, 30'h1060,    0, I2, 30'hC03,    4));
        vecs.push_back(mk(0, 0, 32'h0,        0, 30'h0,       0, 30'h0,     0, 30'h1060,    0, I2, 30'hC03,    4));
        vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 30'h0,       0, 30'h0,     1, 30'h1060,    0, I2, 30'hC03,    4));
        vecs.push_back(mk(1, 0, 32'h0,        0, 30'h0,       0, 30'h0,     0, 30'h1060,    0, I2, 30'hC03,    4));
        vecs.push_back(mk(0, 1, I3,           0, 30'h0,       0, 30'h0,     0, 30'h1060,    1, I3, 30'h1060,   4));
        vecs.push_back(mk(0, 0, 32'h0,        1, 30'h1061,    0, 30'h0,     1, 30'h1061,    0, I3, 30'h1060,   5));
        // flush on the grant cycle -> DRAIN
        vecs.push_back(mk(1, 0, 32'h0,        0, 30'h0,       1, 30'h1100,  0, 30'h1100,    0, I3, 30'h1060,   5));
        vecs.push_back(mk(0, 1, 32'hBAD0BAD0, 0, 30'h0,       0, 30'h0,     1, 30'h1100,    0, I3, 30'h1060,   5));
        // flush on the rvalid cycle -> FETCH, data dropped
        vecs.push_back(mk(1, 0, 32'h0,        0, 30'h0,       0, 30'h0,     0, 30'h1100,    0, I3, 30'h1060,   5));
        vecs.push_back(mk(0, 1, 32'hBAD1BAD1, 0, 30'h0,       1, 30'h1200,  1, 30'h1200,    0, I3, 30'h1060,   5));
        // flush in HOLD overrides inst_ready, count unchanged
        vecs.push_back(mk(1, 0, 32'h0,        0, 30'h0,       0, 30'h0,     0, 30'h1200,    0, I3, 30'h1060,   5));
        vecs.push_back(mk(0, 1, I4,           0, 30'h0,       0, 30'h0,     0, 30'h1200,    1, I4, 30'h1200,   5));
        vecs.push_back(mk(0, 0, 32'h0,        1, 30'h1201,    1, 30'h1300,  1, 30'h1300,    0, I4, 30'h1200,   5));
        // repeated flush while draining keeps retargeting pc
        vecs.push_back(mk(1, 0, 32'h0,        0, 30'h0,       0, 30'h0,     0, 30'h1300,    0, I4, 30'h1200,   5));
        vecs.push_back(mk(0, 0, 32'h0,        0, 30'h0,       1, 30'h1400,  0, 30'h1400,    0, I4, 30'h1200,   5));
        vecs.push_back(mk(1, 0, 32'h0,        0, 30'h0,       1, 30'h1500,  0, 30'h1500,    0, I4, 30'h1200,   5));
        vecs.push_back(mk(0, 1, 32'hBAD2BAD2, 0, 30'h0,       0, 30'h0,     1, 30'h1500,    0, I4, 30'h1200,   5));
        // npc loaded unchecked, including the top of the address space
        vecs.push_back(mk(1, 0, 32'h0,        0, 30'h0,       0, 30'h0,     0, 30'h1500,    0, I4, 30'h1200,   5));
        vecs.push_back(mk(0, 1, I5,           0, 30'h0,       0, 30'h0,     0, 30'h1500,    1, I5, 30'h1500,   5));
        vecs.push_back(mk(0, 0, 32'h0,        1, 30'h3FFFFFFF,0, 30'h0,     1, 30'h3FFFFFFF,0, I5, 30'h1500,   6));

        // reset values while rst_n is held low
        rst_n = 1'b0;
        idle_inputs();
        #12;
        chk_outs("reset", 0, 30'hC00, 0, 32'h0, 30'h0, 0);
        chk("reset.pc", 64'(pc), 64'(30'hC00));
        #10;
        rst_n = 1'b1;
        #1;
        chk_outs("first_fetch", 1, 30'hC00, 0, 32'h0, 30'h0, 0);

        foreach (vecs[i]) begin
            imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rdata;
            inst_ready = vecs[i].rdy; npc = vecs[i].npc;
            flush = vecs[i].fl; flush_pc = vecs[i].flpc;
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].iv,
                     vecs[i].inst, vecs[i].ipc, vecs[i].cnt);
        end

        // asynchronous reset dropped between edges while in HOLD
        idle_inputs();
        imem_gnt = 1;
        @(posedge clk); #1;
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        chk("arst.pre_valid", 64'(inst_valid), 64'(1'b1));
        imem_rvalid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("arst", 0, 30'hC00, 0, 32'h0, 30'h0, 0);
        chk("arst.pc", 64'(pc), 64'(30'hC00));
        #1;
        rst_n = 1'b1;
        #1;
        chk_outs("arst_release", 1, 30'hC00, 0, 32'h0, 30'h0, 0);
        imem_gnt = 1;
        @(posedge clk); #1;
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = D;
        @(posedge clk); #1;
        chk_outs("arst_refetch", 0, 30'hC00, 1, D, 30'hC00, 0);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
